// File: rtl/keypad_operand_entry.sv
// 4x4 active-low keypad scanner with debounce, hex encoding and operand assembly.
// Optional function keys (A-F as load/clear/negate/backspace) enabled by KEYPAD_FUNC_KEYS_EN.
module keypad_operand_entry #(
  parameter int OPERAND_N      = 8,
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_TICKS = 20000
) (
  input  logic                 CLK,
  input  logic                 CLEAR,
  input  logic [3:0]           ROWS,
  output logic [3:0]           COLS,
  output logic [3:0]           KEY_CODE,
  output logic                 KEY_VALID,
  output logic [OPERAND_N-1:0] VALUE,
  output logic                 LOAD_A,
  output logic                 LOAD_B
);

  localparam int SW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, RELEASE} state_t;

  state_t               state;
  logic [3:0]           rows_meta;
  logic [3:0]           srows;
  logic [1:0]           col;
  logic [1:0]           row;
  logic [SW-1:0]        dwell;
  logic [DW-1:0]        db_cnt;
  logic [1:0]           low_row;
  logic                 any_low;
  logic [3:0]           code;
  logic [OPERAND_N-1:0] value_next;
  logic                 load_a_next;
  logic                 load_b_next;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  default: key_map = 4'hD;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    any_low = (srows != 4'hF);
    low_row = 2'd0;
    // Descending scan so the lowest-index low row is the one that sticks.
    for (int r = 3; r >= 0; r--) begin
      if (!srows[r]) low_row = 2'(r);
    end
  end

  assign code = key_map(row, col);

  always_comb begin
    value_next  = (VALUE << 4) | OPERAND_N'(code);
    load_a_next = 1'b0;
    load_b_next = 1'b0;
`ifdef KEYPAD_FUNC_KEYS_EN
    case (code)
      4'hA: begin value_next = VALUE; load_a_next = 1'b1; end
      4'hB: begin value_next = VALUE; load_b_next = 1'b1; end
      4'hC: value_next = '0;
      4'hD: value_next = -VALUE;
      4'hE: value_next = VALUE >> 4;
      4'hF: value_next = VALUE;
      default: ;
    endcase
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      rows_meta <= 4'hF;
      srows     <= 4'hF;
      state     <= SCAN;
      col       <= 2'd0;
      row       <= 2'd0;
      dwell     <= '0;
      db_cnt    <= '0;
      COLS      <= 4'b1110;
      KEY_CODE  <= 4'h0;
      KEY_VALID <= 1'b0;
      VALUE     <= '0;
      LOAD_A    <= 1'b0;
      LOAD_B    <= 1'b0;
    end else begin
      rows_meta <= ROWS;
      srows     <= rows_meta;
      KEY_VALID <= 1'b0;
      LOAD_A    <= 1'b0;
      LOAD_B    <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == SCAN_LAST) begin
            dwell <= '0;
            if (any_low) begin
              row    <= low_row;
              db_cnt <= '0;
              state  <= DEBOUNCE;
            end else begin
              col  <= col + 2'd1;
              COLS <= {COLS[2:0], COLS[3]};
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (srows[row]) begin
            col   <= col + 2'd1;
            COLS  <= {COLS[2:0], COLS[3]};
            dwell <= '0;
            state <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            // Outputs are registered here so they are visible during the ACCEPT cycle.
            KEY_VALID <= 1'b1;
            KEY_CODE  <= code;
            VALUE     <= value_next;
            LOAD_A    <= load_a_next;
            LOAD_B    <= load_b_next;
            state     <= ACCEPT;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        ACCEPT: begin
          db_cnt <= '0;
          state  <= RELEASE;
        end
        default: begin
          if (!srows[row]) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_LAST) begin
            col   <= col + 2'd1;
            COLS  <= {COLS[2:0], COLS[3]};
            dwell <= '0;
            state <= SCAN;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed bench for keypad_operand_entry with a behavioural 4x4 keypad model.
// Function-key scenario runs when KEYPAD_FUNC_KEYS_EN is defined; otherwise hex digit entry is checked.
module tb_keypad_operand_entry;

  logic       CLK;
  logic       CLEAR;
  logic [3:0] ROWS;
  logic [3:0] COLS;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic [7:0] VALUE;
  logic       LOAD_A;
  logic       LOAD_B;

  logic [3:0][3:0] pressed;  // [row][col]
  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  int load_a_count = 0;
  int load_b_count = 0;
  logic [7:0] load_a_value = 8'h00;

  keypad_operand_entry #(
    .OPERAND_N(8), .SCAN_TICKS(4), .DEBOUNCE_TICKS(8)
  ) dut (
    .CLK(CLK), .CLEAR(CLEAR), .ROWS(ROWS), .COLS(COLS),
    .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .VALUE(VALUE),
    .LOAD_A(LOAD_A), .LOAD_B(LOAD_B)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // A row reads low only when a pressed switch sits on the column being driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) ROWS[r] = ~|(pressed[r] & ~COLS);
  end

  always @(negedge CLK) begin
    if (KEY_VALID === 1'b1) valid_count++;
    if (LOAD_A === 1'b1) begin load_a_count++; load_a_value = VALUE; end
    if (LOAD_B === 1'b1) load_b_count++;
  end

  task automatic wait_cols(input logic [3:0] target, input string tag);
    int n = 0;
    while (COLS !== target && n < 64) begin @(negedge CLK); n++; end
    checks++;
    if (COLS !== target) begin
      errors++;
      $display("FAIL %s: COLS=%b expected %b", tag, COLS, target);
    end
  endtask

  task automatic press_key(input int r, input int c, input string tag);
    int start = valid_count;
    pressed[r][c] = 1'b1;
    repeat (60) @(negedge CLK);
    pressed[r][c] = 1'b0;
    checks++;
    if (valid_count - start != 1) begin
      errors++;
      $display("FAIL %s_pulses: got %0d expected 1", tag, valid_count - start);
    end
    repeat (40) @(negedge CLK);
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    CLEAR = 1'b1;
    repeat (3) @(negedge CLK);
    CLEAR = 1'b0;
    checks += 6;
    if (COLS !== 4'b1110) begin errors++; $display("FAIL reset_cols: got %b expected 1110", COLS); end
    if (KEY_CODE !== 4'h0) begin errors++; $display("FAIL reset_code: got %h expected 0", KEY_CODE); end
    if (KEY_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", KEY_VALID); end
    if (VALUE !== 8'h00) begin errors++; $display("FAIL reset_value: got %h expected 00", VALUE); end
    if (LOAD_A !== 1'b0) begin errors++; $display("FAIL reset_load_a: got %b expected 0", LOAD_A); end
    if (LOAD_B !== 1'b0) begin errors++; $display("FAIL reset_load_b: got %b expected 0", LOAD_B); end
  endtask

  task automatic test_single_key();
    int start = valid_count;
    pressed[1][1] = 1'b1;
    repeat (200) @(negedge CLK);
    checks++;
    if (valid_count - start != 1) begin
      errors++;
      $display("FAIL hold_no_repeat: got %0d pulses expected 1", valid_count - start);
    end
    pressed[1][1] = 1'b0;
    repeat (40) @(negedge CLK);
    checks += 3;
    if (valid_count - start != 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", valid_count - start); end
    if (KEY_CODE !== 4'h5) begin errors++; $display("FAIL single_code: got %h expected 5", KEY_CODE); end
    if (VALUE !== 8'h05) begin errors++; $display("FAIL single_value: got %h expected 05", VALUE); end
  endtask

  task automatic test_sequence();
    int start;
    do_clear();
    start = valid_count;
    press_key(2, 0, "seq7");
    checks++;
    if (VALUE !== 8'h07) begin errors++; $display("FAIL seq_value7: got %h expected 07", VALUE); end
    press_key(0, 2, "seq3");
    checks++;
    if (VALUE !== 8'h73) begin errors++; $display("FAIL seq_value73: got %h expected 73", VALUE); end
    press_key(2, 2, "seq9");
    checks += 2;
    if (VALUE !== 8'h39) begin errors++; $display("FAIL seq_value39: got %h expected 39", VALUE); end
    if (valid_count - start != 3) begin errors++; $display("FAIL seq_pulses: got %0d expected 3", valid_count - start); end
  endtask

  task automatic test_bounce();
    int start = valid_count;
    logic [3:0] expect_seq [4];
    logic [3:0] prev;
    int n;
    expect_seq[0] = 4'b1101; expect_seq[1] = 4'b1011;
    expect_seq[2] = 4'b0111; expect_seq[3] = 4'b1110;
    for (int i = 0; i < 10; i++) begin
      pressed[1][1] = ~pressed[1][1];
      repeat (3) @(negedge CLK);
    end
    pressed[1][1] = 1'b0;
    repeat (20) @(negedge CLK);
    checks++;
    if (valid_count != start) begin errors++; $display("FAIL bounce_pulses: got %0d expected 0", valid_count - start); end
    wait_cols(4'b1110, "bounce_cols_start");
    prev = COLS;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (COLS === prev && n < 16) begin @(negedge CLK); n++; end
      checks++;
      if (COLS !== expect_seq[i]) begin
        errors++;
        $display("FAIL bounce_rotate%0d: COLS=%b expected %b", i, COLS, expect_seq[i]);
      end
      prev = COLS;
    end
  endtask

  task automatic test_multi_key();
    int start = valid_count;
    pressed[0][2] = 1'b1;
    pressed[2][2] = 1'b1;
    repeat (60) @(negedge CLK);
    checks += 2;
    if (KEY_CODE !== 4'h3) begin errors++; $display("FAIL multi_code: got %h expected 3", KEY_CODE); end
    if (valid_count - start != 1) begin errors++; $display("FAIL multi_pulses: got %0d expected 1", valid_count - start); end
    pressed[1][0] = 1'b1;
    repeat (100) @(negedge CLK);
    pressed = '0;
    repeat (60) @(negedge CLK);
    checks += 3;
    if (valid_count - start != 1) begin errors++; $display("FAIL multi_ignored: got %0d pulses expected 1", valid_count - start); end
    if (KEY_CODE !== 4'h3) begin errors++; $display("FAIL multi_code_hold: got %h expected 3", KEY_CODE); end
    if (VALUE !== 8'h93) begin errors++; $display("FAIL multi_value: got %h expected 93", VALUE); end
  endtask

  task automatic test_clear_mid_debounce();
    int start;
    int n;
    wait_cols(4'b1110, "clr_sync");
    pressed[2][1] = 1'b1;
    wait_cols(4'b1101, "clr_col1");
    repeat (6) @(negedge CLK);
    start = valid_count;
    do_clear();
    checks += 3;
    if (COLS !== 4'b1110) begin errors++; $display("FAIL clr_cols: got %b expected 1110", COLS); end
    if (VALUE !== 8'h00) begin errors++; $display("FAIL clr_value: got %h expected 00", VALUE); end
    if (KEY_VALID !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b expected 0", KEY_VALID); end
    repeat (10) @(negedge CLK);
    checks++;
    if (valid_count != start) begin errors++; $display("FAIL clr_no_accept: got %0d pulses expected 0", valid_count - start); end
    n = 0;
    while (valid_count == start && n < 100) begin @(negedge CLK); n++; end
    pressed[2][1] = 1'b0;
    repeat (40) @(negedge CLK);
    checks += 3;
    if (valid_count - start != 1) begin errors++; $display("FAIL clr_restart_pulses: got %0d expected 1", valid_count - start); end
    if (KEY_CODE !== 4'h8) begin errors++; $display("FAIL clr_restart_code: got %h expected 8", KEY_CODE); end
    if (VALUE !== 8'h08) begin errors++; $display("FAIL clr_restart_value: got %h expected 08", VALUE); end
  endtask

`ifdef KEYPAD_FUNC_KEYS_EN
  task automatic test_func_keys();
    do_clear();
    press_key(1, 1, "fn5");
    checks++;
    if (VALUE !== 8'h05) begin errors++; $display("FAIL fn_value5: got %h expected 05", VALUE); end
    press_key(3, 3, "fnD");
    checks += 2;
    if (VALUE !== 8'hFB) begin errors++; $display("FAIL fn_negate: got %h expected FB", VALUE); end
    if (KEY_CODE !== 4'hD) begin errors++; $display("FAIL fn_code_d: got %h expected D", KEY_CODE); end
    press_key(0, 3, "fnA");
    checks += 4;
    if (load_a_count != 1) begin errors++; $display("FAIL fn_load_a_count: got %0d expected 1", load_a_count); end
    if (load_a_value !== 8'hFB) begin errors++; $display("FAIL fn_load_a_value: got %h expected FB", load_a_value); end
    if (VALUE !== 8'hFB) begin errors++; $display("FAIL fn_a_value: got %h expected FB", VALUE); end
    if (load_b_count != 0) begin errors++; $display("FAIL fn_load_b_count: got %0d expected 0", load_b_count); end
    press_key(2, 3, "fnC");
    checks++;
    if (VALUE !== 8'h00) begin errors++; $display("FAIL fn_clear: got %h expected 00", VALUE); end
    press_key(1, 1, "fn5b");
    press_key(0, 2, "fn3");
    press_key(3, 0, "fnE");
    checks++;
    if (VALUE !== 8'h05) begin errors++; $display("FAIL fn_backspace: got %h expected 05", VALUE); end
  endtask
`else
  task automatic test_hex_digits();
    press_key(3, 3, "hexD");
    checks += 2;
    if (VALUE !== 8'h8D) begin errors++; $display("FAIL hex_value_8d: got %h expected 8D", VALUE); end
    if (KEY_CODE !== 4'hD) begin errors++; $display("FAIL hex_code_d: got %h expected D", KEY_CODE); end
    press_key(3, 0, "hexE");
    press_key(0, 3, "hexA");
    checks += 3;
    if (VALUE !== 8'hEA) begin errors++; $display("FAIL hex_value_ea: got %h expected EA", VALUE); end
    if (load_a_count != 0) begin errors++; $display("FAIL hex_load_a: got %0d expected 0", load_a_count); end
    if (load_b_count != 0) begin errors++; $display("FAIL hex_load_b: got %0d expected 0", load_b_count); end
  endtask
`endif

  initial begin
    CLEAR   = 1'b1;
    pressed = '0;
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_multi_key();
    test_clear_mid_debounce();
`ifdef KEYPAD_FUNC_KEYS_EN
    test_func_keys();
`else
    test_hex_digits();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
